alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Sits directly upstream of the 64-bit ALU as the ID/EX pipeline register.
- Decodes RV64I opcode/funct3/funct7 into the 4-bit ALU control code and selects operand B (register or sign-extended immediate).
- Registers the result together with writeback/memory side-band bits behind a single-entry valid/ready handshake.
- Supports stall (backpressure) and flush.

Parameters:
- XLEN, 64, datapath width of operands and immediates.
- RADDR_W, 5, register-address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  raw instruction word.
- rs1_data  in  XLEN  register-file read port 1.
- rs2_data  in  XLEN  register-file read port 2.
- flush  in  1  squash held and incoming instruction.
- out_valid  out  1  registered instruction valid for ALU.
- out_ready  in  1  ALU/EX consumer accepts.
- alu_rs1  out  XLEN  ALU operand A.
- alu_rs2  out  XLEN  ALU operand B (rs2_data or immediate).
- alu_control  out  4  ALU code: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU.
- store_data  out  XLEN  rs2_data passed through for stores.
- rd_addr  out  RADDR_W  instr[11:7].
- reg_write  out  1  writeback enable.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  conditional branch; funct3 passed on branch_f3.
- branch_f3  out  3  instr[14:12] for branch resolution.
- illegal  out  1  unsupported opcode or funct encoding.

Behaviour:
- Reset (sync): all registered outputs 0, out_valid=0. Reset mid-transfer discards the held entry with no output handshake.
- in_ready = !out_valid || out_ready (combinational). Capture occurs when in_valid && in_ready && !flush.
- Latency 1 cycle: captured fields appear on the outputs the cycle after capture.
- Hold: when out_valid && !out_ready, every output is held stable.
- out_valid next state, in priority order:
  - flush → 0
  - capture → 1
  - out_ready → 0
  - otherwise hold.
- flush beats simultaneous capture; the incoming instruction is dropped. Data registers may keep stale values whenever out_valid=0.
- Decode for R-type (0110011), operand B = rs2_data, reg_write=1, by funct3:
  - 000: ADD if funct7=0000000, SUB if funct7=0100000.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRL if funct7=0000000, SRA if funct7=0100000.
  - Any other funct7 → illegal.
- Decode for I-ALU (0010011), operand B = sign-extended instr[31:20], reg_write=1:
  - funct3 as for R-type, except 000 is always ADD.
  - Shifts use instr[25:20] as shamt. Operand B = zero-extended shamt; instr[31:26] must be 000000 (SLLI/SRLI) or 010000 (SRAI), else illegal.
- Load (0000011): ADD, operand B = I-immediate, mem_read=1, reg_write=1.
- Store (0100011): ADD, operand B = sign-extended {instr[31:25],instr[11:7]}, mem_write=1, reg_write=0.
- Branch (1100011), operand B = rs2_data, branch=1, reg_write=0, by funct3:
  - 000/001 → SUB.
  - 100/101 → SLT.
  - 110/111 → SLTU.
  - 010/011 → illegal.
- Any other opcode: illegal=1, alu_control=0010, all write/mem/branch enables 0.
- An illegal instruction still handshakes normally (out_valid=1) so a later stage can trap.
- alu_rs1 = rs1_data in every case. Immediates are sign-extended to XLEN bits.

Test Plan:
- Reset then R-type ADD: instr=0x002081B3, rs1=5, rs2=7 → next cycle out_valid=1, alu_control=0010, alu_rs2=7, rd_addr=3, reg_write=1.
- SRAI: instr=0x4030D093 → alu_control=0111, alu_rs2=3. SUB instr=0x40208133 → 0110. ADDI imm=-1 (instr=0xFFF08093) → alu_rs2=0xFFFFFFFFFFFFFFFF.
- Branch BLTU instr=0x0020E463 → alu_control=1001, branch=1, branch_f3=110, reg_write=0. Store SD instr=0x0020B423 → ADD, alu_rs2=8, mem_write=1, store_data=rs2_data.
- Backpressure: capture with out_ready=0 for 3 cycles → outputs stable and in_ready=0. Raise out_ready → in_ready=1 the same cycle; back-to-back capture of the next instruction without a bubble.
- Flush and in_valid asserted in the same cycle while an entry is held → out_valid=0 next cycle, the new instruction is not captured, and a subsequent capture works normally.
- Illegal opcode 0x0000007F → out_valid=1, illegal=1, alu_control=0010, all enables 0. Reset asserted while holding → out_valid=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register: decodes RV64I ALU/load/store/branch instructions into the
// 4-bit ALU control code, selects operand B and holds the result behind valid/ready.
module alu_issue_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_rs1,
    output logic [XLEN-1:0]    alu_rs2,
    output logic [3:0]         alu_control,
    output logic [XLEN-1:0]    store_data,
    output logic [RADDR_W-1:0] rd_addr,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               branch,
    output logic [2:0]         branch_f3,
    output logic               illegal
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_ALT  = 6'b010000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] shamt;
    logic            capture;
    logic            unused_instr_bits;

    logic [3:0]      base_ctl;
    logic [3:0]      dec_ctl;
    logic [XLEN-1:0] dec_b;
    logic            dec_rw;
    logic            dec_mr;
    logic            dec_mw;
    logic            dec_br;
    logic            dec_ill;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign shamt   = XLEN'(instr[25:20]);
    assign unused_instr_bits = ^instr[19:15];

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // funct3 -> ALU code shared by R-type and I-ALU (base funct7/funct6 encodings)
    always_comb begin
        base_ctl = ALU_ADD;
        case (funct3)
            3'b000:  base_ctl = ALU_ADD;
            3'b001:  base_ctl = ALU_SLL;
            3'b010:  base_ctl = ALU_SLT;
            3'b011:  base_ctl = ALU_SLTU;
            3'b100:  base_ctl = ALU_XOR;
            3'b101:  base_ctl = ALU_SRL;
            3'b110:  base_ctl = ALU_OR;
            default: base_ctl = ALU_AND;
        endcase
    end

    // Illegal encodings are forced to a side-effect-free ADD with all enables low.
    always_comb begin
        dec_ctl = ALU_ADD;
        dec_b   = imm_i;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_br  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_R: begin
                dec_b  = rs2_data;
                dec_rw = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec_ctl = base_ctl;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_ctl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_ctl = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_I: begin
                dec_rw  = 1'b1;
                dec_ctl = base_ctl;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_b = shamt;
                    if (instr[31:26] == F6_BASE) begin
                        dec_ctl = base_ctl;
                    end else if (funct3 == 3'b101 && instr[31:26] == F6_ALT) begin
                        dec_ctl = ALU_SRA;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                dec_mr = 1'b1;
                dec_rw = 1'b1;
            end
            OPC_STORE: begin
                dec_b  = imm_s;
                dec_mw = 1'b1;
            end
            OPC_BRANCH: begin
                dec_b  = rs2_data;
                dec_br = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec_ctl = ALU_SUB;
                    3'b100, 3'b101: dec_ctl = ALU_SLT;
                    3'b110, 3'b111: dec_ctl = ALU_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_ctl = ALU_ADD;
            dec_rw  = 1'b0;
            dec_mr  = 1'b0;
            dec_mw  = 1'b0;
            dec_br  = 1'b0;
        end
    end

    // Pipeline register; data only moves on capture so a stalled entry stays put.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            alu_rs1     <= '0;
            alu_rs2     <= '0;
            alu_control <= '0;
            store_data  <= '0;
            rd_addr     <= '0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch      <= 1'b0;
            branch_f3   <= '0;
            illegal     <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (capture) begin
                alu_rs1     <= rs1_data;
                alu_rs2     <= dec_b;
                alu_control <= dec_ctl;
                store_data  <= rs2_data;
                rd_addr     <= RADDR_W'(instr[11:7]);
                reg_write   <= dec_rw;
                mem_read    <= dec_mr;
                mem_write   <= dec_mw;
                branch      <= dec_br;
                branch_f3   <= funct3;
                illegal     <= dec_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, stall/flush/reset sequences and
// a randomized handshake run scored against an instruction-level reference model.
module tb_alu_issue_stage;

    localparam logic [3:0] C_AND  = 4'd0;
    localparam logic [3:0] C_OR   = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_XOR  = 4'd3;
    localparam logic [3:0] C_SLL  = 4'd4;
    localparam logic [3:0] C_SRL  = 4'd5;
    localparam logic [3:0] C_SUB  = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd7;
    localparam logic [3:0] C_SLT  = 4'd8;
    localparam logic [3:0] C_SLTU = 4'd9;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_rs1;
    logic [63:0] alu_rs2;
    logic [3:0]  alu_control;
    logic [63:0] store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [2:0]  branch_f3;
    logic        illegal;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_control(alu_control), .store_data(store_data),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .branch_f3(branch_f3),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // partial: funct-level illegal, only the pass-through fields and illegal are defined
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sd;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic [2:0]  bf3;
        logic        ill;
        logic        b_dc;
        logic        partial;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] w;
        logic [63:0] r1;
        logic [63:0] r2;
        exp_t        e;
    } vec_t;

    int ntests = 0;
    int nfail  = 0;

    logic [3:0] base_code [8] = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check_exp(input string n, input exp_t e);
        chk({n, " alu_rs1"}, alu_rs1, e.a);
        chk({n, " store_data"}, store_data, e.sd);
        chk({n, " rd_addr"}, 64'(rd_addr), 64'(e.rd));
        chk({n, " illegal"}, 64'(illegal), 64'(e.ill));
        if (!e.partial) begin
            chk({n, " alu_control"}, 64'(alu_control), 64'(e.ctl));
            chk({n, " reg_write"}, 64'(reg_write), 64'(e.rw));
            chk({n, " mem_read"}, 64'(mem_read), 64'(e.mr));
            chk({n, " mem_write"}, 64'(mem_write), 64'(e.mw));
            chk({n, " branch"}, 64'(branch), 64'(e.br));
            if (!e.b_dc) chk({n, " alu_rs2"}, alu_rs2, e.b);
            if (e.br) chk({n, " branch_f3"}, 64'(branch_f3), 64'(e.bf3));
        end
    endtask

    // Instruction-level meaning of each encoding.
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] r1,
                                   input logic [63:0] r2);
        exp_t e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm_i;
        logic [63:0] imm_s;
        logic [63:0] sh;
        f3    = w[14:12];
        f7    = w[31:25];
        imm_i = 64'($signed(w[31:20]));
        imm_s = 64'($signed({w[31:25], w[11:7]}));
        sh    = 64'(w[25:20]);
        e     = '0;
        e.a   = r1;
        e.sd  = r2;
        e.rd  = w[11:7];
        e.ctl = C_ADD;
        case (w[6:0])
            7'h33: begin
                e.b  = r2;
                e.rw = 1'b1;
                if (f7 == 7'h00)                   e.ctl = base_code[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.ctl = C_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.ctl = C_SRA;
                else begin e.ill = 1'b1; e.partial = 1'b1; end
            end
            7'h13: begin
                e.rw = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = sh;
                    if (w[31:26] == 6'd0)                         e.ctl = base_code[f3];
                    else if (f3 == 3'd5 && w[31:26] == 6'b010000) e.ctl = C_SRA;
                    else begin e.ill = 1'b1; e.partial = 1'b1; end
                end else begin
                    e.b   = imm_i;
                    e.ctl = base_code[f3];
                end
            end
            7'h03: begin e.b = imm_i; e.mr = 1'b1; e.rw = 1'b1; end
            7'h23: begin e.b = imm_s; e.mw = 1'b1; end
            7'h63: begin
                e.b   = r2;
                e.br  = 1'b1;
                e.bf3 = f3;
                if (f3 < 3'd2)      e.ctl = C_SUB;
                else if (f3 < 3'd4) begin e.ill = 1'b1; e.partial = 1'b1; end
                else if (f3 < 3'd6) e.ctl = C_SLT;
                else                e.ctl = C_SLTU;
            end
            default: begin e.ill = 1'b1; e.b_dc = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] sd, input logic [3:0] ctl,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic br, input logic [2:0] bf3,
                                input logic ill, input logic bdc);
        exp_t e;
        e = '{a: a, b: b, sd: sd, ctl: ctl, rd: rd, rw: rw, mr: mr, mw: mw, br: br,
              bf3: bf3, ill: ill, b_dc: bdc, partial: 1'b0};
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] r1,
                         input logic [63:0] r2);
        in_valid = v;
        instr    = w;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic check_reset_state(input string n);
        chk({n, " out_valid"}, 64'(out_valid), 64'd0);
        chk({n, " alu_rs1"}, alu_rs1, 64'd0);
        chk({n, " alu_rs2"}, alu_rs2, 64'd0);
        chk({n, " alu_control"}, 64'(alu_control), 64'd0);
        chk({n, " store_data"}, store_data, 64'd0);
        chk({n, " rd_addr"}, 64'(rd_addr), 64'd0);
        chk({n, " enables"}, 64'({reg_write, mem_read, mem_write, branch}), 64'd0);
        chk({n, " branch_f3"}, 64'(branch_f3), 64'd0);
        chk({n, " illegal"}, 64'(illegal), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        exp_t        ea;
        exp_t        eb;
        exp_t        m_e;
        logic        m_v;
        logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
        logic [31:0] w;

        reset = 1'b1;
        out_ready = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        repeat (3) tick();
        check_reset_state("reset");
        chk("reset in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        vecs[0] = '{"add",   32'h002081B3, 64'd5, 64'd7,
                    mk(64'd5, 64'd7, 64'd7, C_ADD, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0)};
        vecs[1] = '{"srai",  32'h4030D093, 64'h8000_0000_0000_0010, 64'd99,
                    mk(64'h8000_0000_0000_0010, 64'd3, 64'd99, C_SRA, 5'd1, 1, 0, 0, 0, 3'd0, 0, 0)};
        vecs[2] = '{"sub",   32'h40208133, 64'd20, 64'd6,
                    mk(64'd20, 64'd6, 64'd6, C_SUB, 5'd2, 1, 0, 0, 0, 3'd0, 0, 0)};
        vecs[3] = '{"addi",  32'hFFF08093, 64'd1, 64'd2,
                    mk(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, C_ADD, 5'd1, 1, 0, 0, 0, 3'd0, 0, 0)};
        vecs[4] = '{"bltu",  32'h0020E463, 64'd3, 64'd4,
                    mk(64'd3, 64'd4, 64'd4, C_SLTU, 5'd8, 0, 0, 0, 1, 3'd6, 0, 0)};
        vecs[5] = '{"sd",    32'h0020B423, 64'h1000, 64'hDEAD_BEEF_0000_1234,
                    mk(64'h1000, 64'd8, 64'hDEAD_BEEF_0000_1234, C_ADD, 5'd8, 0, 0, 1, 0, 3'd0, 0, 0)};
        vecs[6] = '{"illop", 32'h0000007F, 64'd11, 64'd12,
                    mk(64'd11, 64'd0, 64'd12, C_ADD, 5'd0, 0, 0, 0, 0, 3'd0, 1, 1)};

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].w, vecs[i].r1, vecs[i].r2);
            tick();
            drive(1'b0, 32'd0, 64'd0, 64'd0);
            chk({vecs[i].name, " out_valid"}, 64'(out_valid), 64'd1);
            check_exp(vecs[i].name, vecs[i].e);
        end
        tick();
        chk("drain out_valid", 64'(out_valid), 64'd0);

        // Backpressure: hold A three cycles while B waits, then B follows with no bubble
        out_ready = 1'b0;
        ea = model(32'h002081B3, 64'd100, 64'd200);
        eb = model(32'h40208133, 64'd300, 64'd400);
        drive(1'b1, 32'h002081B3, 64'd100, 64'd200);
        tick();
        drive(1'b1, 32'h40208133, 64'd300, 64'd400);
        for (int k = 0; k < 3; k++) begin
            chk("stall out_valid", 64'(out_valid), 64'd1);
            chk("stall in_ready", 64'(in_ready), 64'd0);
            check_exp("stall", ea);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk("b2b out_valid", 64'(out_valid), 64'd1);
        check_exp("b2b", eb);
        tick();
        chk("b2b drain out_valid", 64'(out_valid), 64'd0);

        // Flush with an incoming instruction while an entry is held
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 64'd1, 64'd2);
        tick();
        chk("flush pre out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        drive(1'b1, 32'h40208133, 64'd3, 64'd4);
        tick();
        flush = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h0020B423, 64'd55, 64'd66);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk("post-flush out_valid", 64'(out_valid), 64'd1);
        check_exp("post-flush", model(32'h0020B423, 64'd55, 64'd66));
        tick();

        // Reset while an entry is stalled
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF08093, 64'd9, 64'd9);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("hold-reset");
        out_ready = 1'b1;

        // Randomized traffic against the reference model
        m_v = 1'b0;
        m_e = '0;
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 5)];
            if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
            drive($urandom_range(0, 9) < 7, w, {$urandom, $urandom}, {$urandom, $urandom});
            flush     = $urandom_range(0, 11) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            chk("rand in_ready", 64'(in_ready), 64'(!m_v || out_ready));
            if (flush) begin
                m_v = 1'b0;
            end else if (in_valid && (!m_v || out_ready)) begin
                m_v = 1'b1;
                m_e = model(instr, rs1_data, rs2_data);
            end else if (out_ready) begin
                m_v = 1'b0;
            end
            tick();
            chk("rand out_valid", 64'(out_valid), 64'(m_v));
            if (m_v) check_exp("rand", m_e);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
